ysyx_22040931_alu_issue: RTL and testbench
==========================================

Name: ysyx_22040931_alu_issue

Overview:
- Initiator side of the execute-unit handshake (id_valid/alu_ready toward the ALU, alu_valid/ex_ready back from it).
- Sits between the ID pipeline register and the ALU. It latches one decoded op and drives operands and op to the ALU, holding them stable until the ALU finishes.
- Captures the ALU result into a one-entry writeback register with valid/ready toward WB.
- Handles both single-cycle ops (alu_valid = alu_ready = 1) and multi-cycle div ops, and supports flush of an in-flight op.

Parameters:
- DATA_W, 64, operand/result width
- PC_W, 64, pc width
- OP_W, 8, ALU op code width
- RD_W, 5, destination register index width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of the held/in-flight op
- in_valid  in  1  ID has an op
- in_ready  out  1  block accepts the op this cycle
- in_op  in  OP_W  ALU op code
- in_num1, in_num2, in_imm  in  DATA_W  operands
- in_pc  in  PC_W  instruction pc
- in_rd  in  RD_W  destination register
- id_valid  out  1  op presented to ALU
- alu_ready  in  1  ALU accepts op
- alu_valid  in  1  ALU result valid
- ex_ready  out  1  result may be consumed this cycle
- op, num1, num2, imm  out  OP_W/DATA_W  held op and operands to ALU
- pc  out  PC_W  held pc to ALU
- out  in  DATA_W  ALU result
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  WB consumes entry
- wb_data  out  DATA_W  captured result
- wb_rd  out  RD_W  captured destination

Behaviour:
- Reset (reset=0, async): state=IDLE; wb_valid=0; all data outputs 0; id_valid=0, ex_ready=0, in_ready=0 while reset is asserted.
- States: IDLE (no op held), BUSY (op held, not yet accepted), WAIT (accepted, awaiting result), DRAIN (flushed op still in ALU).
- wb_free = !wb_valid || wb_ready.
- id_valid = (state==BUSY).
- ex_ready = (state==BUSY || state==WAIT) && wb_free && !flush.
- ex_ready = 1 in DRAIN regardless of wb_free.
- done = ex_ready && alu_valid && (state==WAIT || (state==BUSY && alu_ready)).
- in_ready = !flush && (state==IDLE || done).
- Accept (in_valid && in_ready): latch in_* into the held regs and go to BUSY.
- Single-cycle op is issued in the next cycle. Back-to-back ops get one op per cycle when WB never stalls.
- BUSY transitions:
  - done -> capture.
  - alu_ready && !done -> WAIT.
  - !alu_ready -> stay BUSY.
- WAIT: done -> capture; otherwise stay. Held op/operands stay stable; the ALU must hold alu_valid and its result until ex_ready.
- Capture: wb_data<=out, wb_rd<=held rd, wb_valid<=1. Next state is BUSY if a new op is accepted in the same cycle, else IDLE.
- wb_valid clears on wb_ready when there is no same-cycle capture. A capture and a drain in the same cycle overwrite the entry; wb_valid stays 1.
- Multi-cycle ALUs keep alu_valid=0 in their accept cycle. Latency from accept to wb_valid: 2 cycles for single-cycle ops; N+2 for an N-cycle divide.
- Flush:
  - In IDLE: no effect.
  - In BUSY with !alu_ready: go to IDLE and discard the op.
  - In BUSY with alu_ready, or in WAIT: if alu_valid that cycle, go to IDLE; else go to DRAIN.
  - DRAIN: in_ready=0. Stay until alu_valid, discard the result, then IDLE.
  - Flush has priority over in_valid. wb entry is never flushed; it is older.
- Reset mid-operation returns to IDLE; the ALU shares the reset.

Optional Feature:
- Macro YSYX_22040931_ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_ops (32-bit) and perf_stall (32-bit), reset 0, saturating at 0xFFFFFFFF.
  - perf_ops increments on each capture.
  - perf_stall increments on each cycle in BUSY/WAIT/DRAIN without done.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD, num1=5, num2=7, alu single-cycle, wb_ready=1 -> id_valid one cycle after accept; wb_valid=1, wb_data=12 two cycles after accept; in_ready stays 1.
- Four back-to-back ADDs, wb_ready=1 -> one capture per cycle, wb_data sequence correct, no bubbles.
- DIV 100/7 on a 33-cycle divider -> id_valid high for 1 cycle; op/num1/num2 stable for 33 cycles; wb_data=14 one cycle after alu_valid; in_ready=0 during WAIT.
- wb_ready=0 for 5 cycles with a second ADD held -> ex_ready=0, state holds, wb_data keeps the first result; second result captured the cycle after wb_ready returns.
- Flush in WAIT of a DIV, alu_valid 10 cycles later -> state DRAIN, in_ready=0, result discarded, wb_valid unchanged, then IDLE.
- Assert reset low mid-DIV asynchronously -> wb_valid=0 and id_valid=0 immediately; after release, a fresh ADD 1+1 yields wb_data=2.

Source files
------------

// File: rtl/ysyx_22040931_alu_issue.sv
// ysyx_22040931_alu_issue
// Issue stage between the ID pipeline register and the ALU. Holds one decoded
// op, presents it to the ALU with an id_valid/alu_ready handshake, waits for
// alu_valid and captures the result into a one-entry writeback register that
// drains toward WB with wb_valid/wb_ready. A flush kills the held op; if the
// ALU has already taken it, the result is drained and thrown away.
//
// Optional build macro: YSYX_22040931_ALU_ISSUE_PERF_EN
//   adds saturating 32-bit perf_ops / perf_stall counters and their ports.

module ysyx_22040931_alu_issue #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int OP_W   = 8,
    parameter int RD_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    // decoded op from ID
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_num1,
    input  logic [DATA_W-1:0] in_num2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [RD_W-1:0]   in_rd,
    // ALU handshake
    output logic              id_valid,
    input  logic              alu_ready,
    input  logic              alu_valid,
    output logic              ex_ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] out,
    // writeback entry
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd
`ifdef YSYX_22040931_ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // nothing held
        ST_BUSY  = 2'd1,  // op held, ALU has not taken it yet
        ST_WAIT  = 2'd2,  // ALU took the op, result pending
        ST_DRAIN = 2'd3   // op was flushed after the ALU took it
    } state_t;

    state_t              r_state;

    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_num1;
    logic [DATA_W-1:0]   r_num2;
    logic [DATA_W-1:0]   r_imm;
    logic [PC_W-1:0]     r_pc;
    logic [RD_W-1:0]     r_rd;

    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_data;
    logic [RD_W-1:0]     r_wb_rd;

    logic                w_wb_free;
    logic                w_issuing;
    logic                w_ex_ready;
    logic                w_done;
    logic                w_in_ready;
    logic                w_accept;

    // The wb slot can take a new result if it is empty or being read this cycle.
    assign w_wb_free  = !r_wb_valid || wb_ready;
    assign w_issuing  = (r_state == ST_BUSY) || (r_state == ST_WAIT);

    // In DRAIN the result is unwanted, so it is consumed regardless of WB.
    assign w_ex_ready = (w_issuing && w_wb_free && !flush) || (r_state == ST_DRAIN);

    // A result is captured only for a live op the ALU has actually accepted.
    assign w_done     = w_ex_ready && alu_valid &&
                        ((r_state == ST_WAIT) || ((r_state == ST_BUSY) && alu_ready));

    // Gated with reset so nothing is offered upstream while reset is held.
    assign w_in_ready = reset && !flush && ((r_state == ST_IDLE) || w_done);
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready   = w_in_ready;
    assign id_valid   = (r_state == ST_BUSY);
    assign ex_ready   = w_ex_ready;

    assign op         = r_op;
    assign num1       = r_num1;
    assign num2       = r_num2;
    assign imm        = r_imm;
    assign pc         = r_pc;

    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_wb_rd;

    // Issue FSM: flush outranks completion and new accepts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_BUSY;
                    else          r_state <= ST_IDLE;
                end
                ST_BUSY: begin
                    if (flush) begin
                        // Not yet taken, or finishing right now: simply drop it.
                        if (!alu_ready || alu_valid) r_state <= ST_IDLE;
                        else                         r_state <= ST_DRAIN;
                    end else if (w_done) begin
                        if (w_accept) r_state <= ST_BUSY;
                        else          r_state <= ST_IDLE;
                    end else if (alu_ready) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        if (alu_valid) r_state <= ST_IDLE;
                        else           r_state <= ST_DRAIN;
                    end else if (w_done) begin
                        if (w_accept) r_state <= ST_BUSY;
                        else          r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (alu_valid) r_state <= ST_IDLE;
                    else           r_state <= ST_DRAIN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Held op and operands: loaded on accept, otherwise stable toward the ALU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op   <= {OP_W{1'b0}};
            r_num1 <= {DATA_W{1'b0}};
            r_num2 <= {DATA_W{1'b0}};
            r_imm  <= {DATA_W{1'b0}};
            r_pc   <= {PC_W{1'b0}};
            r_rd   <= {RD_W{1'b0}};
        end else if (w_accept) begin
            r_op   <= in_op;
            r_num1 <= in_num1;
            r_num2 <= in_num2;
            r_imm  <= in_imm;
            r_pc   <= in_pc;
            r_rd   <= in_rd;
        end else begin
            r_op   <= r_op;
            r_num1 <= r_num1;
            r_num2 <= r_num2;
            r_imm  <= r_imm;
            r_pc   <= r_pc;
            r_rd   <= r_rd;
        end
    end

    // Writeback entry: capture overwrites (valid stays high), else drain on wb_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= {DATA_W{1'b0}};
            r_wb_rd    <= {RD_W{1'b0}};
        end else if (w_done) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= out;
            r_wb_rd    <= r_rd;
        end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end

`ifdef YSYX_22040931_ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stall;

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;

    // Saturating counters: completed ops, and occupied cycles without completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_ops   <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_done && (r_perf_ops != 32'hFFFF_FFFF)) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end else begin
                r_perf_ops <= r_perf_ops;
            end
            if ((r_state != ST_IDLE) && !w_done && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end else begin
                r_perf_stall <= r_perf_stall;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040931_alu_issue.sv
// Directed bench for ysyx_22040931_alu_issue. A small behavioural ALU model
// answers single-cycle ADDs combinationally and DIVs after DIV_LAT cycles,
// holding alu_valid and its result until ex_ready.

module tb_ysyx_22040931_alu_issue;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_DIV  = 8'h02;
    localparam int         DIV_LAT = 33;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [63:0] in_num1, in_num2, in_imm, in_pc;
    logic [4:0]  in_rd;
    logic        id_valid;
    logic        alu_ready;
    logic        alu_valid;
    logic        ex_ready;
    logic [7:0]  op;
    logic [63:0] num1, num2, imm, pc;
    logic [63:0] out;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int bad;

    ysyx_22040931_alu_issue dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_num1   (in_num1),
        .in_num2   (in_num2),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .in_rd     (in_rd),
        .id_valid  (id_valid),
        .alu_ready (alu_ready),
        .alu_valid (alu_valid),
        .ex_ready  (ex_ready),
        .op        (op),
        .num1      (num1),
        .num2      (num2),
        .imm       (imm),
        .pc        (pc),
        .out       (out),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU model state
    logic        a_busy;
    logic        a_hold;
    logic [63:0] a_res;
    int          a_cnt;

    // ALU model outputs: held result, or immediate ADD when free.
    always_comb begin
        alu_ready = 1'b0;
        alu_valid = 1'b0;
        out       = 64'd0;
        if (a_hold) begin
            alu_valid = 1'b1;
            out       = a_res;
        end else if (!a_busy) begin
            alu_ready = 1'b1;
            if (id_valid && (op == OP_ADD)) begin
                alu_valid = 1'b1;
                out       = num1 + num2;
            end
        end
    end

    // ALU model sequencing: divide countdown and result hold until ex_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_busy <= 1'b0;
            a_hold <= 1'b0;
            a_res  <= 64'd0;
            a_cnt  <= 0;
        end else if (a_hold) begin
            if (ex_ready) a_hold <= 1'b0;
        end else if (a_busy) begin
            if (a_cnt == 1) begin
                a_busy <= 1'b0;
                a_hold <= 1'b1;
            end
            a_cnt <= a_cnt - 1;
        end else if (id_valid) begin
            if (op == OP_ADD) begin
                if (!ex_ready) begin
                    a_hold <= 1'b1;
                    a_res  <= num1 + num2;
                end
            end else begin
                a_busy <= 1'b1;
                a_cnt  <= DIV_LAT - 1;
                a_res  <= num1 / num2;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = o;
        in_num1  = a;
        in_num2  = b;
        in_rd    = rd;
    endtask

    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] vs [4];

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_op    = 8'h00;
        in_num1  = 64'd0;
        in_num2  = 64'd0;
        in_imm   = 64'd0;
        in_pc    = 64'd0;
        in_rd    = 5'd0;
        wb_ready = 1'b1;
        va = '{64'd1, 64'd10, 64'd100, 64'd7};
        vb = '{64'd2, 64'd20, 64'd200, 64'd8};
        vs = '{64'd3, 64'd30, 64'd300, 64'd15};

        // reset state
        #2;
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_id_valid", {63'd0, id_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
        check("rst_wb_data",  wb_data, 64'd0);
        check("rst_num1",     num1, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // single ADD 5+7
        drive(OP_ADD, 64'd5, 64'd7, 5'd3);
        in_pc  = 64'h8000_0000;
        in_imm = 64'h55;
        #1;
        check("add_in_ready_idle", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("add_id_valid", {63'd0, id_valid}, 64'd1);
        check("add_num1", num1, 64'd5);
        check("add_num2", num2, 64'd7);
        check("add_op",   {56'd0, op}, {56'd0, OP_ADD});
        check("add_pc",   pc, 64'h8000_0000);
        check("add_imm",  imm, 64'h55);
        check("add_wb_valid_early", {63'd0, wb_valid}, 64'd0);
        check("add_in_ready_busy", {63'd0, in_ready}, 64'd1);
        cyc();
        check("add_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("add_wb_data",  wb_data, 64'd12);
        check("add_wb_rd",    {59'd0, wb_rd}, 64'd3);
        check("add_id_valid_off", {63'd0, id_valid}, 64'd0);
        cyc();
        check("add_wb_drained", {63'd0, wb_valid}, 64'd0);

        // four back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, va[i], vb[i], 5'(i + 10));
            #1;
            check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            cyc();
            if (i > 0) begin
                check("b2b_wb_valid", {63'd0, wb_valid}, 64'd1);
                check("b2b_wb_data", wb_data, vs[i-1]);
            end
        end
        in_valid = 1'b0;
        cyc();
        check("b2b_wb_data_last", wb_data, vs[3]);
        check("b2b_wb_rd_last", {59'd0, wb_rd}, 64'd13);
        cyc();
        check("b2b_wb_drained", {63'd0, wb_valid}, 64'd0);

        // DIV 100/7 on a 33-cycle divider
        drive(OP_DIV, 64'd100, 64'd7, 5'd5);
        cyc();
        in_valid = 1'b0;
        #1;
        check("div_id_valid", {63'd0, id_valid}, 64'd1);
        check("div_in_ready_busy", {63'd0, in_ready}, 64'd0);
        cyc();
        check("div_id_valid_once", {63'd0, id_valid}, 64'd0);
        bad = 0;
        for (int k = 2; k <= 33; k++) begin
            if (in_ready !== 1'b0 || num1 !== 64'd100 || num2 !== 64'd7 ||
                op !== OP_DIV || wb_valid !== 1'b0) bad++;
            cyc();
        end
        check("div_stable_wait", 64'(bad), 64'd0);
        check("div_wb_valid_pre", {63'd0, wb_valid}, 64'd0);
        check("div_in_ready_done", {63'd0, in_ready}, 64'd1);
        cyc();
        check("div_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("div_wb_data", wb_data, 64'd14);
        check("div_wb_rd", {59'd0, wb_rd}, 64'd5);
        cyc();

        // WB stall with a second ADD held
        wb_ready = 1'b0;
        drive(OP_ADD, 64'd3, 64'd4, 5'd1);
        cyc();
        drive(OP_ADD, 64'd20, 64'd22, 5'd2);
        #1;
        check("stall_in_ready_first", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (ex_ready !== 1'b0 || wb_data !== 64'd7 || wb_valid !== 1'b1 ||
                in_ready !== 1'b0) bad++;
            cyc();
        end
        check("stall_hold", 64'(bad), 64'd0);
        wb_ready = 1'b1;
        #1;
        check("stall_ex_ready_back", {63'd0, ex_ready}, 64'd1);
        check("stall_wb_data_old", wb_data, 64'd7);
        cyc();
        check("stall_wb_data_new", wb_data, 64'd42);
        check("stall_wb_rd_new", {59'd0, wb_rd}, 64'd2);
        check("stall_wb_valid", {63'd0, wb_valid}, 64'd1);
        cyc();
        check("stall_wb_drained", {63'd0, wb_valid}, 64'd0);

        // flush in IDLE blocks the accept
        drive(OP_ADD, 64'd1, 64'd1, 5'd9);
        flush = 1'b1;
        #1;
        check("flush_idle_in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_idle_no_issue", {63'd0, id_valid}, 64'd0);

        // flush a DIV in WAIT while the wb entry is stalled
        wb_ready = 1'b0;
        drive(OP_ADD, 64'd9, 64'd9, 5'd4);
        cyc();
        drive(OP_DIV, 64'd50, 64'd5, 5'd6);
        cyc();
        in_valid = 1'b0;
        cyc();
        repeat (22) cyc();
        flush = 1'b1;
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        check("flush_ex_ready", {63'd0, ex_ready}, 64'd0);
        cyc();
        flush = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (ex_ready !== 1'b1 || in_ready !== 1'b0 || id_valid !== 1'b0 ||
                wb_data !== 64'd18 || wb_valid !== 1'b1 || wb_rd !== 5'd4) bad++;
            cyc();
        end
        check("drain_hold", 64'(bad), 64'd0);
        check("drain_idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("drain_idle_ex_ready", {63'd0, ex_ready}, 64'd0);
        check("drain_wb_data_kept", wb_data, 64'd18);
        check("drain_wb_valid_kept", {63'd0, wb_valid}, 64'd1);
        wb_ready = 1'b1;
        cyc();
        check("drain_wb_drained", {63'd0, wb_valid}, 64'd0);

        // asynchronous reset in the middle of a DIV
        wb_ready = 1'b0;
        drive(OP_ADD, 64'd2, 64'd2, 5'd8);
        cyc();
        drive(OP_DIV, 64'd100, 64'd7, 5'd5);
        cyc();
        in_valid = 1'b0;
        check("rstmid_id_valid_pre", {63'd0, id_valid}, 64'd1);
        check("rstmid_wb_valid_pre", {63'd0, wb_valid}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rstmid_id_valid", {63'd0, id_valid}, 64'd0);
        check("rstmid_in_ready", {63'd0, in_ready}, 64'd0);
        check("rstmid_wb_data", wb_data, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();
        wb_ready = 1'b1;
        drive(OP_ADD, 64'd1, 64'd1, 5'd7);
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("post_rst_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("post_rst_wb_data", wb_data, 64'd2);
        check("post_rst_wb_rd", {59'd0, wb_rd}, 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
